// File: rtl/switches_to_leds_pkg.sv
// rtl/switches_to_leds_pkg.sv - shared defaults and counter sizing for switches_to_leds
package switches_to_leds_pkg;

  localparam int N_DEFAULT               = 4;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

  // One extra bit over clog2 keeps DEBOUNCE_CYCLES-1 representable even when DEBOUNCE_CYCLES is 1.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/switches_to_leds_debounce_bit.sv
// rtl/switches_to_leds_debounce_bit.sv - one channel: 2-flop sync, optional debounce counter, LED and change pulse
// Debounce counter present only when SWITCHES_TO_LEDS_DEBOUNCE_EN is defined.
module debounce_bit
  import switches_to_leds_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_switch,
  output logic o_LED,
  output logic o_LED_changed
);

  logic sync1;
  logic sync2;
  logic led_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= i_switch;
      sync2 <= sync1;
    end
  end

`ifdef SWITCHES_TO_LEDS_DEBOUNCE_EN
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // Counter only advances while sync2 disagrees with the LED; it clears on load or on agreement, so it never wraps.
  always_comb begin
    led_next = o_LED;
    cnt_next = '0;
    if (sync2 != o_LED) begin
      if (cnt == CNT_LAST) begin
        led_next = sync2;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end
`else
  assign led_next = sync2;

  // DEBOUNCE_CYCLES has no effect in this build.
  if (DEBOUNCE_CYCLES < 1) begin : g_debounce_ignored
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_LED         <= 1'b0;
      o_LED_changed <= 1'b0;
    end else begin
      o_LED         <= led_next;
      o_LED_changed <= led_next ^ o_LED;
    end
  end

endmodule

// File: rtl/switches_to_leds.sv
// rtl/switches_to_leds.sv - N independent switch-to-LED channels
// Optional debounce enabled by defining SWITCHES_TO_LEDS_DEBOUNCE_EN.
module switches_to_leds
  import switches_to_leds_pkg::*;
#(
  parameter int N               = N_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_switch,
  output logic [N-1:0] o_LED,
  output logic [N-1:0] o_LED_changed
);

  for (genvar k = 0; k < N; k++) begin : g_ch
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_switch     (i_switch[k]),
      .o_LED        (o_LED[k]),
      .o_LED_changed(o_LED_changed[k])
    );
  end

endmodule

// File: tb/tb_switches_to_leds.sv
// tb/tb_switches_to_leds.sv - randomized self-checking bench for switches_to_leds
module tb_switches_to_leds;

  localparam int N     = 4;
  localparam int DEB   = 4;
`ifdef SWITCHES_TO_LEDS_DEBOUNCE_EN
  localparam int D_EFF = DEB;
`else
  localparam int D_EFF = 1;
`endif
  localparam int HIST  = 4096;

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [N-1:0] i_switch = '0;
  logic [N-1:0] o_LED;
  logic [N-1:0] o_LED_changed;

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0] eff_h [HIST];
  bit           rst_h [HIST];
  int           t = -1;
  logic [N-1:0] m_led = '0;
  logic [N-1:0] m_chg = '0;

  switches_to_leds #(
    .N              (N),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_switch     (i_switch),
    .o_LED        (o_LED),
    .o_LED_changed(o_LED_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %b, expected %b", tag, t, got, exp);
    end
  endtask

  // Value the second synchronizer stage presents at edge idx.
  function automatic logic [N-1:0] s2_at(input int idx);
    if (idx < 2) return '0;
    if (rst_h[idx-1]) return '0;
    return eff_h[idx-2];
  endfunction

  // LED bit k flips at edge t when the last D_EFF edges were all out of reset and all showed the opposite level.
  task automatic model_edge(input logic [N-1:0] sw, input logic rst);
    logic [N-1:0] nxt;
    logic [N-1:0] s2v;
    bit ok;
    t++;
    eff_h[t] = rst ? '0 : sw;
    rst_h[t] = rst;
    if (rst) begin
      m_led = '0;
      m_chg = '0;
    end else begin
      nxt = m_led;
      for (int k = 0; k < N; k++) begin
        ok = 1'b1;
        for (int j = 0; j < D_EFF; j++) begin
          if (t - j < 0 || rst_h[t-j]) begin
            ok = 1'b0;
          end else begin
            s2v = s2_at(t - j);
            if (s2v[k] == m_led[k]) ok = 1'b0;
          end
        end
        if (ok) nxt[k] = ~m_led[k];
      end
      m_chg = nxt ^ m_led;
      m_led = nxt;
    end
  endtask

  task automatic step(input logic [N-1:0] sw, input logic rst, input string tag);
    i_switch = sw;
    i_rst    = rst;
    @(posedge clk);
    model_edge(sw, rst);
    @(negedge clk);
    check({tag, "_led"}, o_LED, m_led);
    check({tag, "_chg"}, o_LED_changed, m_chg);
  endtask

  task automatic hold(input logic [N-1:0] sw, input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) step(sw, 1'b0, tag);
  endtask

  logic [N-1:0] seq_vals [5];
  int lat;
  logic [N-1:0] rv;

  initial begin
    seq_vals[0] = 4'b0000;
    seq_vals[1] = 4'b0100;
    seq_vals[2] = 4'b1010;
    seq_vals[3] = 4'b0101;
    seq_vals[4] = 4'b1010;

    // Reset with all switches high: outputs must stay dark.
    step(4'b1111, 1'b1, "reset");
    step(4'b1111, 1'b1, "reset");
    check("reset_led_const", o_LED, 4'b0000);
    check("reset_chg_const", o_LED_changed, 4'b0000);

    for (int s = 0; s < 5; s++) hold(seq_vals[s], 20, "seq");

    hold(4'b0000, 10, "pre_glitch");
    hold(4'b0100, 2, "glitch");
    hold(4'b0000, 12, "post_glitch");
    check("glitch_led_const", o_LED, 4'b0000);

    hold(4'b0001, 2, "midcount");
    step(4'b0001, 1'b1, "midcount_rst");
    check("midcount_rst_led_const", o_LED, 4'b0000);
    hold(4'b0001, 12, "midcount_after");
    check("midcount_final_const", o_LED, 4'b0001);

    // Absolute latency of a clean step, measured independently of the model.
    hold(4'b0000, 12, "lat_pre");
    lat = 0;
    i_switch = 4'b1010;
    for (int i = 0; i < 20 && o_LED !== 4'b1010; i++) begin
      step(4'b1010, 1'b0, "lat");
      lat++;
    end
    check("latency_edges", 4'(lat), 4'(D_EFF + 2));
    check("latency_led", o_LED, 4'b1010);
    check("latency_chg", o_LED_changed, 4'b1010);
    step(4'b1010, 1'b0, "lat_post");
    check("latency_chg_one_cycle", o_LED_changed, 4'b0000);

    for (int r = 0; r < 400 && t < HIST - 20; r++) begin
      rv = 4'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        step(rv, 1'b1, "rand_rst");
      end else begin
        hold(rv, $urandom_range(1, 8), "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
